// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
// Imported by the receiver top level and its testbench.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } rx_state_e;

  // Expected parity bit for up to 9 data bits; unused upper bits must be zero.
  function automatic logic par_calc(input logic [8:0] data, input parity_e mode);
    return (^data) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Serial line plus output-FIFO handshake of the UART receiver.
// The master side is the receiver; the slave side is the line driver and consumer.
interface uart_rx_param_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);

  logic                          rx;
  logic [DATA_BITS-1:0]          rx_data;
  logic                          rx_perr;
  logic                          rx_ferr;
  logic                          rx_valid;
  logic                          rx_ready;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          overrun;
  logic                          break_det;
  logic                          err_clr;

  modport master (
    input  rx, rx_ready, err_clr,
    output rx_data, rx_perr, rx_ferr, rx_valid, fifo_count, overrun, break_det
  );

  modport slave (
    output rx, rx_ready, err_clr,
    input  rx_data, rx_perr, rx_ferr, rx_valid, fifo_count, overrun, break_det
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO holding received words; head word is read straight from storage.
// A write into a full FIFO is only accepted when a read happens in the same cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     clr_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_rd;
  logic             do_wr;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];
  assign count   = cnt;

  // Storage is cleared on reset so the head word reads as zero when idle.
  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchroniser, bit timer, 3-sample majority vote,
// frame FSM with parity/framing/break detection, feeding an output FIFO.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int      CLKS_PER_BIT = 434,
  parameter int      DATA_BITS    = 8,
  parameter parity_e PARITY       = PAR_NONE,
  parameter int      STOP_BITS    = 1,
  parameter int      FIFO_DEPTH   = 4
) (
  input logic             clock,
  input logic             clr_n,
  uart_rx_param_if.master bus
);

  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int BW    = $clog2(DATA_BITS + 1);
  localparam int MID   = CLKS_PER_BIT / 2;
  localparam int WIDTH = DATA_BITS + 2;

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MIDM  = CW'(MID - 1);
  localparam logic [CW-1:0] CNT_MID   = CW'(MID);
  localparam logic [CW-1:0] CNT_MIDP  = CW'(MID + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  logic                          sync1;
  logic                          sync2;
  logic                          rxs_prev;
  rx_state_e                     state;
  logic [CW-1:0]                 cnt;
  logic [BW-1:0]                 bit_idx;
  logic                          stop_idx;
  logic [DATA_BITS-1:0]          shreg;
  logic                          perr;
  logic                          ferr;
  logic                          par_vote;
  logic                          s0;
  logic                          s1;
  logic                          brk_pulse;
  logic                          overrun_q;

  logic                          decide;
  logic                          vote;
  logic                          brk_cond;
  logic                          push;
  logic [WIDTH-1:0]              push_word;
  logic                          pop;
  logic [WIDTH-1:0]              fifo_rd;
  logic [$clog2(FIFO_DEPTH):0]   fifo_cnt;
  logic                          fifo_full;
  logic                          fifo_empty;

  // Two-flop synchroniser plus a delayed copy for start-edge detection; idles high.
  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      sync1    <= bus.rx;
      sync2    <= sync1;
      rxs_prev <= sync2;
    end
  end

  // The third vote sample is the live synchronised value at the decision count.
  always_comb begin
    decide    = (state != IDLE) && (state != BRK_WAIT) && (cnt == CNT_MIDP);
    vote      = (s0 & s1) | (s0 & sync2) | (s1 & sync2);
    brk_cond  = (shreg == '0) && ((PARITY == PAR_NONE) || !par_vote) && !vote;
    push      = (state == STOP) && decide && (stop_idx == STOP_LAST)
                && !((stop_idx == 1'b0) && brk_cond);
    push_word = {perr, ferr | ~vote, shreg};
  end

  // The PARITY parameter hides the state literal of the same name, hence uart_pkg::PARITY.
  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      shreg     <= '0;
      perr      <= 1'b0;
      ferr      <= 1'b0;
      par_vote  <= 1'b0;
      s0        <= 1'b1;
      s1        <= 1'b1;
      brk_pulse <= 1'b0;
    end else begin
      brk_pulse <= 1'b0;
      if ((state != IDLE) && (state != BRK_WAIT)) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        if (cnt == CNT_MIDM) s0 <= sync2;
        if (cnt == CNT_MID)  s1 <= sync2;
      end
      case (state)
        IDLE: begin
          if (rxs_prev && !sync2) begin
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          if (decide) begin
            if (vote) begin
              state <= IDLE;
            end else begin
              state    <= DATA;
              bit_idx  <= '0;
              stop_idx <= 1'b0;
              perr     <= 1'b0;
              ferr     <= 1'b0;
              par_vote <= 1'b0;
            end
          end
        end
        DATA: begin
          if (decide) begin
            shreg <= {vote, shreg[DATA_BITS-1:1]};
            if (bit_idx == BIT_LAST) begin
              state <= (PARITY == PAR_NONE) ? STOP : uart_pkg::PARITY;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        uart_pkg::PARITY: begin
          if (decide) begin
            perr     <= (vote != par_calc(9'(shreg), PARITY));
            par_vote <= vote;
            state    <= STOP;
          end
        end
        STOP: begin
          if (decide) begin
            ferr <= ferr | ~vote;
            if ((stop_idx == 1'b0) && brk_cond) begin
              brk_pulse <= 1'b1;
              state     <= BRK_WAIT;
            end else if (stop_idx == STOP_LAST) begin
              state <= IDLE;
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end
        end
        BRK_WAIT: begin
          if (sync2) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pop = !fifo_empty && bus.rx_ready;

  // A frame that finds the FIFO full with no pop is dropped; the drop beats a clear.
  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      overrun_q <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overrun_q <= 1'b1;
    end else if (bus.err_clr) begin
      overrun_q <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .clr_n   (clr_n),
    .wr_en   (push),
    .wr_data (push_word),
    .rd_en   (bus.rx_ready),
    .rd_data (fifo_rd),
    .count   (fifo_cnt),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign bus.rx_data    = fifo_rd[DATA_BITS-1:0];
  assign bus.rx_ferr    = fifo_rd[DATA_BITS];
  assign bus.rx_perr    = fifo_rd[DATA_BITS+1];
  assign bus.rx_valid   = !fifo_empty;
  assign bus.fifo_count = fifo_cnt;
  assign bus.overrun    = overrun_q;
  assign bus.break_det  = brk_pulse;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: an 8N1 receiver at a short divisor and an
// even-parity receiver at the full 434 divisor, driven with hand-built frames.
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int CPB_A = 16;
  localparam int CPB_B = 434;

  logic clock;
  logic clr_n;

  int checks;
  int failures;
  int brk_pulses;

  logic [9:0] exp_a [$];
  logic [9:0] exp_b [$];

  uart_rx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ifa ();
  uart_rx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ifb ();

  uart_rx_param #(
    .CLKS_PER_BIT (CPB_A),
    .DATA_BITS    (8),
    .PARITY       (PAR_NONE),
    .STOP_BITS    (1),
    .FIFO_DEPTH   (4)
  ) dut_a (
    .clock (clock),
    .clr_n (clr_n),
    .bus   (ifa.master)
  );

  uart_rx_param #(
    .CLKS_PER_BIT (CPB_B),
    .DATA_BITS    (8),
    .PARITY       (PAR_EVEN),
    .STOP_BITS    (1),
    .FIFO_DEPTH   (4)
  ) dut_b (
    .clock (clock),
    .clr_n (clr_n),
    .bus   (ifb.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic drive_bit(input bit sel, input logic b);
    if (sel) begin
      ifb.rx = b;
      repeat (CPB_B) @(negedge clock);
    end else begin
      ifa.rx = b;
      repeat (CPB_A) @(negedge clock);
    end
  endtask

  // Full frame on either line: start, data LSB first, optional parity, one stop bit.
  task automatic apply_stimulus(input bit sel, input logic [7:0] d, input bit use_par,
                                input logic par_bit, input logic stop_bit);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive_bit(sel, d[i]);
    end
    if (use_par) drive_bit(sel, par_bit);
    drive_bit(sel, stop_bit);
    if (sel) ifb.rx = 1'b1;
    else     ifa.rx = 1'b1;
  endtask

  task automatic idle_bits(input bit sel, input int n);
    for (int i = 0; i < n; i++) begin
      drive_bit(sel, 1'b1);
    end
  endtask

  task automatic expect_word(input bit sel, input logic [7:0] d, input logic pe, input logic fe);
    if (sel) exp_b.push_back({pe, fe, d});
    else     exp_a.push_back({pe, fe, d});
  endtask

  task automatic wait_drain(input bit sel);
    int n;
    int left;
    n    = 0;
    left = sel ? exp_b.size() : exp_a.size();
    while (left != 0 && n < 6000) begin
      @(negedge clock);
      n++;
      left = sel ? exp_b.size() : exp_a.size();
    end
    checks++;
    if (left != 0) begin
      failures++;
      $display("[TB] FAIL drain_%0d pending=%0d required=0", sel, left);
    end
    repeat (3) @(negedge clock);
  endtask

  // Monitors: a pop happens at the next rising edge whenever valid and ready are both high.
  initial begin
    logic [9:0] got;
    logic [9:0] want;
    forever begin
      @(negedge clock);
      #1;
      if (ifa.break_det) brk_pulses++;
      if (ifa.rx_valid && ifa.rx_ready) begin
        got = {ifa.rx_perr, ifa.rx_ferr, ifa.rx_data};
        if (exp_a.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL word_a unexpected actual=0x%0h required=none", got);
        end else begin
          want = exp_a.pop_front();
          check_output("word_a", int'(got), int'(want));
        end
      end
    end
  end

  initial begin
    logic [9:0] got;
    logic [9:0] want;
    forever begin
      @(negedge clock);
      #1;
      if (ifb.rx_valid && ifb.rx_ready) begin
        got = {ifb.rx_perr, ifb.rx_ferr, ifb.rx_data};
        if (exp_b.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL word_b unexpected actual=0x%0h required=none", got);
        end else begin
          want = exp_b.pop_front();
          check_output("word_b", int'(got), int'(want));
        end
      end
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog expired before the run completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks     = 0;
    failures   = 0;
    brk_pulses = 0;
    clr_n      = 1'b0;
    ifa.rx = 1'b1; ifa.rx_ready = 1'b1; ifa.err_clr = 1'b0;
    ifb.rx = 1'b1; ifb.rx_ready = 1'b1; ifb.err_clr = 1'b0;
    repeat (4) @(negedge clock);

    check_output("rst_data",  int'(ifa.rx_data),    0);
    check_output("rst_perr",  int'(ifa.rx_perr),    0);
    check_output("rst_ferr",  int'(ifa.rx_ferr),    0);
    check_output("rst_valid", int'(ifa.rx_valid),   0);
    check_output("rst_count", int'(ifa.fifo_count), 0);
    check_output("rst_ovr",   int'(ifa.overrun),    0);
    check_output("rst_brk",   int'(ifa.break_det),  0);
    clr_n = 1'b1;
    idle_bits(0, 2);

    $display("[TB] basic 8N1 frame 0x9C");
    expect_word(0, 8'h9C, 1'b0, 1'b0);
    apply_stimulus(0, 8'h9C, 0, 1'b0, 1'b1);
    wait_drain(0);

    $display("[TB] one-cycle start glitch");
    ifa.rx = 1'b0;
    @(negedge clock);
    ifa.rx = 1'b1;
    repeat (3 * CPB_A) @(negedge clock);
    check_output("glitch_count", int'(ifa.fifo_count), 0);
    check_output("glitch_valid", int'(ifa.rx_valid),   0);
    expect_word(0, 8'hA5, 1'b0, 1'b0);
    apply_stimulus(0, 8'hA5, 0, 1'b0, 1'b1);
    wait_drain(0);

    $display("[TB] overrun with five frames into a four-deep FIFO");
    ifa.rx_ready = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      if (v <= 4) expect_word(0, 8'(v), 1'b0, 1'b0);
      apply_stimulus(0, 8'(v), 0, 1'b0, 1'b1);
    end
    repeat (4) @(negedge clock);
    check_output("ovr_count", int'(ifa.fifo_count), 4);
    check_output("ovr_flag",  int'(ifa.overrun),    1);
    ifa.rx_ready = 1'b1;
    wait_drain(0);
    check_output("ovr_empty",  int'(ifa.fifo_count), 0);
    check_output("ovr_sticky", int'(ifa.overrun),    1);
    ifa.err_clr = 1'b1;
    @(negedge clock);
    ifa.err_clr = 1'b0;
    @(negedge clock);
    check_output("ovr_clear", int'(ifa.overrun), 0);

    $display("[TB] break: line low for two frame times");
    brk_pulses = 0;
    ifa.rx = 1'b0;
    repeat (20 * CPB_A) @(negedge clock);
    check_output("brk_pulses", brk_pulses, 1);
    check_output("brk_count",  int'(ifa.fifo_count), 0);
    idle_bits(0, 2);
    expect_word(0, 8'h5A, 1'b0, 1'b0);
    apply_stimulus(0, 8'h5A, 0, 1'b0, 1'b1);
    wait_drain(0);
    check_output("brk_single", brk_pulses, 1);

    $display("[TB] framing error on 0x3C");
    expect_word(0, 8'h3C, 1'b0, 1'b1);
    apply_stimulus(0, 8'h3C, 0, 1'b0, 1'b0);
    idle_bits(0, 2);
    wait_drain(0);

    $display("[TB] reset in the middle of a data bit");
    ifa.rx_ready = 1'b0;
    apply_stimulus(0, 8'h77, 0, 1'b0, 1'b1);
    idle_bits(0, 1);
    check_output("pre_rst_count", int'(ifa.fifo_count), 1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    ifa.rx = 1'b0;
    repeat (CPB_A / 2) @(negedge clock);
    clr_n = 1'b0;
    repeat (3) @(negedge clock);
    check_output("mid_rst_valid", int'(ifa.rx_valid),   0);
    check_output("mid_rst_count", int'(ifa.fifo_count), 0);
    check_output("mid_rst_data",  int'(ifa.rx_data),    0);
    ifa.rx = 1'b1;
    repeat (3) @(negedge clock);
    clr_n = 1'b1;
    ifa.rx_ready = 1'b1;
    idle_bits(0, 2);
    expect_word(0, 8'hC3, 1'b0, 1'b0);
    apply_stimulus(0, 8'hC3, 0, 1'b0, 1'b1);
    wait_drain(0);

    $display("[TB] even parity at the full divisor");
    idle_bits(1, 1);
    expect_word(1, 8'h9C, 1'b0, 1'b0);
    apply_stimulus(1, 8'h9C, 1, 1'b0, 1'b1);
    expect_word(1, 8'h9C, 1'b1, 1'b0);
    apply_stimulus(1, 8'h9C, 1, 1'b1, 1'b1);
    wait_drain(1);
    check_output("par_count", int'(ifb.fifo_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
